atm_bank_responder: RTL and testbench

- Bank-side responder for the ATM controller. Serves the controller's PIN-check, balance, withdraw, deposit, transfer and eject requests over a valid/ready request channel. Returns status and balance over a valid/ready response channel.
- Holds the per-account balance ledger, PINs, failed-attempt counters and lockout flags.
- Tracks a single active session (one card inserted at a time).

---
 rtl/atm_bank_responder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_atm_bank_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/atm_bank_responder.sv
// Bank-side responder for the ATM controller: PIN checks, ledger updates and session tracking.
// Optional per-session withdrawal limit is enabled by defining ATM_DAILY_LIMIT_EN.
module atm_bank_responder #(
  parameter int          NUM_ACCOUNTS = 4,
  parameter int          AMT_W        = 16,
  parameter int          INIT_BALANCE = 1000,
  parameter logic [3:0]  DEFAULT_PIN  = 4'b1110,
  parameter int          MAX_TRIES    = 3,
`ifdef ATM_DAILY_LIMIT_EN
  parameter int          DAILY_LIMIT  = 500,
`endif
  localparam int         ACCT_W       = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_opcode,
  input  logic [ACCT_W-1:0] req_acct,
  input  logic [ACCT_W-1:0] req_dest,
  input  logic [AMT_W-1:0]  req_amount,
  input  logic [3:0]        req_pin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_status,
  output logic [AMT_W-1:0]  rsp_balance,
  output logic [1:0]        rsp_tries_left,
  output logic              session_active
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  localparam logic [2:0] OP_EJECT = 3'd0, OP_BALANCE = 3'd1, OP_WITHDRAW = 3'd2,
                         OP_DEPOSIT = 3'd3, OP_TRANSFER = 3'd4, OP_VERIFY = 3'd5;
  localparam logic [2:0] ST_OK = 3'd0, ST_BAD_PIN = 3'd1, ST_LOCKED = 3'd2, ST_NO_FUNDS = 3'd3,
                         ST_BAD_ACCT = 3'd4, ST_OVERFLOW = 3'd5, ST_NO_SESSION = 3'd6,
                         ST_BAD_OP = 3'd7;

  typedef enum logic [1:0] {IDLE, CHECK, EXEC, RESP} state_t;
  state_t state, state_next;

  function automatic logic [1:0] tries_left_f(input logic [FAIL_W-1:0] fail);
    int left;
    left = MAX_TRIES - int'(fail);
    if (left < 0) left = 0;
    else if (left > 3) left = 3;
    return 2'(left);
  endfunction

  logic [AMT_W-1:0]  bal      [NUM_ACCOUNTS];
  logic [3:0]        pins     [NUM_ACCOUNTS];
  logic [FAIL_W-1:0] fail_cnt [NUM_ACCOUNTS];
  logic              locked   [NUM_ACCOUNTS];
  logic              sess_active;
  logic [ACCT_W-1:0] sess_acct;

  logic [2:0]        op_p0;
  logic [ACCT_W-1:0] acct_p0, dest_p0;
  logic [AMT_W-1:0]  amt_p0;
  logic [3:0]        pin_p0;

  logic [2:0]        st_c, st_p1;
  logic [AMT_W-1:0]  src_new_c, src_new_p1, dst_new_c, dst_new_p1, bal_rsp_c, bal_rsp_p1;
  logic [FAIL_W-1:0] fail_new_c, fail_new_p1;
  logic [1:0]        tries_c, tries_p1;
  logic              wr_src_c, wr_src_p1, wr_dst_c, wr_dst_p1, fail_wr_c, fail_wr_p1;
  logic              lock_c, lock_p1, open_c, open_p1, close_c, close_p1;

  logic [AMT_W-1:0]  src_bal, dst_bal;
  logic [FAIL_W-1:0] src_fail;
  logic              src_lock, acct_ok, dest_ok, over_limit;
  logic [AMT_W:0]    dep_sum, xfer_sum;

  assign req_ready      = (state == IDLE);
  assign session_active = sess_active;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (req_valid) state_next = CHECK;
      CHECK: state_next = EXEC;
      EXEC:  state_next = RESP;
      RESP:  if (rsp_valid && rsp_ready) state_next = IDLE;
    endcase
  end

  // Stage p0: request capture
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      op_p0   <= req_opcode;
      acct_p0 <= req_acct;
      dest_p0 <= req_dest;
      amt_p0  <= req_amount;
      pin_p0  <= req_pin;
    end
  end

  assign acct_ok  = int'(acct_p0) < NUM_ACCOUNTS;
  assign dest_ok  = int'(dest_p0) < NUM_ACCOUNTS;
  assign src_bal  = bal[acct_p0];
  assign dst_bal  = bal[dest_p0];
  assign src_fail = fail_cnt[acct_p0];
  assign src_lock = locked[acct_p0];
  assign dep_sum  = {1'b0, src_bal} + {1'b0, amt_p0};
  assign xfer_sum = {1'b0, dst_bal} + {1'b0, amt_p0};

`ifdef ATM_DAILY_LIMIT_EN
  logic [AMT_W-1:0] accum;
  logic [AMT_W:0]   lim_sum;
  logic             spend_c, spend_p1;
  assign lim_sum    = {1'b0, accum} + {1'b0, amt_p0};
  assign over_limit = lim_sum > (AMT_W+1)'(DAILY_LIMIT);
`else
  assign over_limit = 1'b0;
`endif

  // Eject never fails, so it bypasses the account and lock checks.
  always_comb begin
    st_c       = ST_OK;
    src_new_c  = src_bal;
    dst_new_c  = dst_bal;
    fail_new_c = src_fail;
    wr_src_c   = 1'b0;
    wr_dst_c   = 1'b0;
    fail_wr_c  = 1'b0;
    lock_c     = 1'b0;
    open_c     = 1'b0;
    close_c    = 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
    spend_c    = 1'b0;
`endif
    if (op_p0 > OP_VERIFY) st_c = ST_BAD_OP;
    else if (op_p0 == OP_EJECT) close_c = 1'b1;
    else if (!acct_ok) st_c = ST_BAD_ACCT;
    else if (src_lock) st_c = ST_LOCKED;
    else if (op_p0 != OP_VERIFY && !(sess_active && sess_acct == acct_p0)) st_c = ST_NO_SESSION;
    else begin
      case (op_p0)
        OP_WITHDRAW: begin
          if (amt_p0 > src_bal || over_limit) st_c = ST_NO_FUNDS;
          else begin
            src_new_c = src_bal - amt_p0;
            wr_src_c  = 1'b1;
`ifdef ATM_DAILY_LIMIT_EN
            spend_c   = 1'b1;
`endif
          end
        end
        OP_DEPOSIT: begin
          if (dep_sum[AMT_W]) st_c = ST_OVERFLOW;
          else begin
            src_new_c = dep_sum[AMT_W-1:0];
            wr_src_c  = 1'b1;
          end
        end
        OP_TRANSFER: begin
          if (!dest_ok || dest_p0 == acct_p0) st_c = ST_BAD_ACCT;
          else if (amt_p0 > src_bal || over_limit) st_c = ST_NO_FUNDS;
          else if (xfer_sum[AMT_W]) st_c = ST_OVERFLOW;
          else begin
            src_new_c = src_bal - amt_p0;
            dst_new_c = xfer_sum[AMT_W-1:0];
            wr_src_c  = 1'b1;
            wr_dst_c  = 1'b1;
`ifdef ATM_DAILY_LIMIT_EN
            spend_c   = 1'b1;
`endif
          end
        end
        OP_VERIFY: begin
          fail_wr_c = 1'b1;
          if (pin_p0 == pins[acct_p0]) begin
            fail_new_c = '0;
            open_c     = 1'b1;
          end else begin
            fail_new_c = src_fail + FAIL_W'(1);
            if (int'(fail_new_c) >= MAX_TRIES) begin
              st_c   = ST_LOCKED;
              lock_c = 1'b1;
            end else st_c = ST_BAD_PIN;
          end
        end
        default: ;
      endcase
    end
    bal_rsp_c = (!acct_ok || st_c == ST_BAD_ACCT) ? '0 : src_new_c;
    tries_c   = acct_ok ? tries_left_f(fail_new_c) : 2'd0;
  end

  // Stage p1: validated request and precomputed ledger values
  always_ff @(posedge clk) begin
    if (state == CHECK) begin
      st_p1       <= st_c;
      src_new_p1  <= src_new_c;
      dst_new_p1  <= dst_new_c;
      fail_new_p1 <= fail_new_c;
      bal_rsp_p1  <= bal_rsp_c;
      tries_p1    <= tries_c;
      wr_src_p1   <= wr_src_c;
      wr_dst_p1   <= wr_dst_c;
      fail_wr_p1  <= fail_wr_c;
      lock_p1     <= lock_c;
      open_p1     <= open_c;
      close_p1    <= close_c;
`ifdef ATM_DAILY_LIMIT_EN
      spend_p1    <= spend_c;
`endif
    end
  end

  // Stage p2: ledger/session commit; reset wins so an aborted request never lands
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal[i]      <= AMT_W'(INIT_BALANCE);
        pins[i]     <= DEFAULT_PIN;
        fail_cnt[i] <= '0;
        locked[i]   <= 1'b0;
      end
      sess_active <= 1'b0;
      sess_acct   <= '0;
    end else if (state == EXEC) begin
      if (wr_src_p1)  bal[acct_p0]      <= src_new_p1;
      if (wr_dst_p1)  bal[dest_p0]      <= dst_new_p1;
      if (fail_wr_p1) fail_cnt[acct_p0] <= fail_new_p1;
      if (lock_p1)    locked[acct_p0]   <= 1'b1;
      if (open_p1) begin
        sess_active <= 1'b1;
        sess_acct   <= acct_p0;
      end
      if (close_p1)   sess_active       <= 1'b0;
    end
  end

`ifdef ATM_DAILY_LIMIT_EN
  always_ff @(posedge clk) begin
    if (reset) accum <= '0;
    else if (state == EXEC) begin
      if (open_p1 || close_p1) accum <= '0;
      else if (spend_p1)       accum <= accum + amt_p0;
    end
  end
`endif

  // Response registers load at the EXEC edge and hold until the handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid      <= 1'b0;
      rsp_status     <= ST_OK;
      rsp_balance    <= '0;
      rsp_tries_left <= tries_left_f('0);
    end else begin
      if (state == EXEC) begin
        rsp_status     <= st_p1;
        rsp_balance    <= bal_rsp_p1;
        rsp_tries_left <= tries_p1;
      end
      rsp_valid <= (state == RESP) && !(rsp_valid && rsp_ready);
    end
  end

endmodule

// File: tb/tb_atm_bank_responder.sv
// Directed scoreboard bench for atm_bank_responder (default parameters).
module tb_atm_bank_responder;

  localparam logic [2:0] OP_EJECT = 3'd0, OP_BALANCE = 3'd1, OP_WITHDRAW = 3'd2,
                         OP_DEPOSIT = 3'd3, OP_TRANSFER = 3'd4, OP_VERIFY = 3'd5;
  localparam logic [2:0] S_OK = 3'd0, S_BAD_PIN = 3'd1, S_LOCKED = 3'd2, S_NO_FUNDS = 3'd3,
                         S_BAD_ACCT = 3'd4, S_OVERFLOW = 3'd5, S_NO_SESSION = 3'd6,
                         S_BAD_OP = 3'd7;

  logic        clk, reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_opcode;
  logic [1:0]  req_acct, req_dest;
  logic [15:0] req_amount;
  logic [3:0]  req_pin;
  logic        rsp_valid, rsp_ready;
  logic [2:0]  rsp_status;
  logic [15:0] rsp_balance;
  logic [1:0]  rsp_tries_left;
  logic        session_active;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] bal;
    logic [1:0]  tries;
    logic        sess;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  atm_bank_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_acct(req_acct), .req_dest(req_dest), .req_amount(req_amount), .req_pin(req_pin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .rsp_tries_left(rsp_tries_left),
    .session_active(session_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expectation, issue one request, then pop and compare on the response.
  task automatic do_req(input string tag, input logic [2:0] op, input logic [1:0] acct,
                        input logic [1:0] dest, input logic [15:0] amt, input logic [3:0] pin,
                        input logic [2:0] est, input logic [15:0] ebal, input logic [1:0] etries,
                        input logic esess, input int hold);
    exp_t e;
    int n;
    e.st = est; e.bal = ebal; e.tries = etries; e.sess = esess;
    sb.push_back(e);
    req_opcode = op; req_acct = acct; req_dest = dest; req_amount = amt; req_pin = pin;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check({tag, "_ready_before"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check({tag, "_latency"}, 32'(n), 32'd3);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      for (int h = 0; h < hold; h++) begin
        check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_hold_status"}, 32'(rsp_status), 32'(e.st));
        check({tag, "_hold_balance"}, 32'(rsp_balance), 32'(e.bal));
        tick();
      end
      check({tag, "_status"}, 32'(rsp_status), 32'(e.st));
      check({tag, "_balance"}, 32'(rsp_balance), 32'(e.bal));
      check({tag, "_tries"}, 32'(rsp_tries_left), 32'(e.tries));
      check({tag, "_session"}, 32'(session_active), 32'(e.sess));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = '0; req_acct = '0; req_dest = '0; req_amount = '0; req_pin = '0;
    tick(); tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_status", 32'(rsp_status), 32'd0);
    check("rst_balance", 32'(rsp_balance), 32'd0);
    check("rst_tries", 32'(rsp_tries_left), 32'd3);
    check("rst_session", 32'(session_active), 32'd0);
    reset = 1'b0;
    tick();

    do_req("verify0",   OP_VERIFY,   2'd0, 2'd0, 16'd0,     4'b1110, S_OK,         16'd1000, 2'd3, 1'b1, 0);
    do_req("badpin1a",  OP_VERIFY,   2'd1, 2'd0, 16'd0,     4'b0000, S_BAD_PIN,    16'd1000, 2'd2, 1'b1, 0);
    do_req("badpin1b",  OP_VERIFY,   2'd1, 2'd0, 16'd0,     4'b0000, S_BAD_PIN,    16'd1000, 2'd1, 1'b1, 0);
    do_req("badpin1c",  OP_VERIFY,   2'd1, 2'd0, 16'd0,     4'b0000, S_LOCKED,     16'd1000, 2'd0, 1'b1, 0);
    do_req("locked1",   OP_VERIFY,   2'd1, 2'd0, 16'd0,     4'b1110, S_LOCKED,     16'd1000, 2'd0, 1'b1, 0);
    do_req("wd300",     OP_WITHDRAW, 2'd0, 2'd0, 16'd300,   4'b0000, S_OK,         16'd700,  2'd3, 1'b1, 0);
    do_req("wd800",     OP_WITHDRAW, 2'd0, 2'd0, 16'd800,   4'b0000, S_NO_FUNDS,   16'd700,  2'd3, 1'b1, 0);
    do_req("wd0",       OP_WITHDRAW, 2'd0, 2'd0, 16'd0,     4'b0000, S_OK,         16'd700,  2'd3, 1'b1, 0);
    do_req("dep_ovf",   OP_DEPOSIT,  2'd0, 2'd0, 16'hFFFF,  4'b0000, S_OVERFLOW,   16'd700,  2'd3, 1'b1, 0);
    do_req("xfer200",   OP_TRANSFER, 2'd0, 2'd2, 16'd200,   4'b0000, S_OK,         16'd500,  2'd3, 1'b1, 0);
    do_req("xfer_self", OP_TRANSFER, 2'd0, 2'd0, 16'd10,    4'b0000, S_BAD_ACCT,   16'd0,    2'd3, 1'b1, 0);
    do_req("eject0",    OP_EJECT,    2'd0, 2'd0, 16'd0,     4'b0000, S_OK,         16'd500,  2'd3, 1'b0, 0);
    do_req("verify2",   OP_VERIFY,   2'd2, 2'd0, 16'd0,     4'b1110, S_OK,         16'd1200, 2'd3, 1'b1, 0);
    do_req("eject2",    OP_EJECT,    2'd2, 2'd0, 16'd0,     4'b0000, S_OK,         16'd1200, 2'd3, 1'b0, 0);
    do_req("nosess",    OP_BALANCE,  2'd0, 2'd0, 16'd0,     4'b0000, S_NO_SESSION, 16'd500,  2'd3, 1'b0, 0);
    do_req("badop",     3'd7,        2'd0, 2'd0, 16'd0,     4'b0000, S_BAD_OP,     16'd500,  2'd3, 1'b0, 0);
    do_req("hold3",     OP_VERIFY,   2'd3, 2'd0, 16'd0,     4'b1110, S_OK,         16'd1000, 2'd3, 1'b1, 5);
    do_req("dep500",    OP_DEPOSIT,  2'd3, 2'd0, 16'd500,   4'b0000, S_OK,         16'd1500, 2'd3, 1'b1, 0);

    // Reset lands while the withdraw sits in EXEC: nothing may come back.
    req_opcode = OP_WITHDRAW; req_acct = 2'd3; req_dest = 2'd0; req_amount = 16'd100;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_valid", 32'(rsp_valid), 32'd0);
      tick();
    end
    rsp_ready = 1'b0;
    check("abort_session", 32'(session_active), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    do_req("post_rst3", OP_VERIFY,   2'd3, 2'd0, 16'd0,     4'b1110, S_OK,         16'd1000, 2'd3, 1'b1, 0);
    do_req("post_rst1", OP_VERIFY,   2'd1, 2'd0, 16'd0,     4'b1110, S_OK,         16'd1000, 2'd3, 1'b1, 0);

`ifdef ATM_DAILY_LIMIT_EN
    do_req("lim_wd1",   OP_WITHDRAW, 2'd1, 2'd0, 16'd300,   4'b0000, S_OK,         16'd700,  2'd3, 1'b1, 0);
    do_req("lim_wd2",   OP_WITHDRAW, 2'd1, 2'd0, 16'd300,   4'b0000, S_NO_FUNDS,   16'd700,  2'd3, 1'b1, 0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
